xs2p_sched: RTL and testbench
=============================

XS2P_SCHED -- requirements
Module: xs2p_sched

Interface
REQ-001 SHALL have parameter BWID, default 8, bits per serial word.
REQ-002 SHALL have parameter NPAR, default 4, words packed per output beat; NPAR >= 2.
REQ-003 SHALL have parameter NCH, default 4, number of requester channels; NCH >= 2.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
REQ-006 SHALL have port i_rdy  input  NCH  channel c holds >= NPAR words ready to read.
REQ-007 SHALL have port o_rd  output  NCH  one-hot read strobe to the granted channel; read latency is 1 cycle.
REQ-008 SHALL have port iv_data  input  NCH*BWID  channel c data in slice [c*BWID +: BWID], valid 1 cycle after o_rd[c].
REQ-009 SHALL have port i_trig  input  NCH  frame-start marker, aligned with iv_data.
REQ-010 SHALL have port ov_data  output  BWID*NPAR  packed beat.
REQ-011 SHALL have port ov_ch  output  clog2(NCH)  source channel of the beat.
REQ-012 SHALL have port o_dv  output  1  beat valid; held until accepted.
REQ-013 SHALL have port i_ordy  input  1  downstream accepts when o_dv & i_ordy.
REQ-014 SHALL have port o_trig  output  1  beat starts a frame (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RD, LAST, HOLD.
REQ-016 IDLE: if any i_rdy=1, SHALL grant the round-robin winner at or after the pointer, go to RD, and set the pointer to winner+1 (mod NCH); no request -> stay in IDLE, pointer unchanged.
REQ-017 RD: SHALL assert o_rd[grant] for exactly NPAR consecutive cycles, starting the cycle after the grant decision; word counter runs 0..NPAR-1; then go to LAST.
REQ-018 SHALL capture the word returned for read k into lane k, bits [k*BWID +: BWID]; the first word goes to the LSB lane.
REQ-019 LAST: SHALL capture lane NPAR-1; if the output slot is free (!o_dv | i_ordy), load ov_data/ov_ch/o_trig, set o_dv, and go to IDLE; otherwise go to HOLD.
REQ-020 HOLD: SHALL keep the packed beat, issue no o_rd, and load the output and go to IDLE on the first cycle the slot is free.
REQ-021 Latency: i_rdy seen in IDLE at cycle t -> o_rd at t+1..t+NPAR -> o_dv at t+NPAR+2 when the slot is free.
REQ-022 o_dv SHALL clear on acceptance unless a new beat is loaded in the same cycle; ov_data/ov_ch/o_trig SHALL be stable while o_dv=1 and i_ordy=0.
REQ-023 i_rdy changes during RD/LAST/HOLD SHALL be ignored; the burst always completes NPAR reads.
REQ-024 o_rd SHALL never have more than one bit set and SHALL be 0 outside RD.

Reset
REQ-025 On reset SHALL set state=IDLE, pointer=0, word counter=0, o_rd=0, o_dv=0, o_trig=0, ov_data=0, ov_ch=0.
REQ-026 Reset mid-burst SHALL abort it; o_rd is 0 from the reset edge; partial data is discarded and is not output.

Configuration
REQ-027 With macro XS2P_SCHED_TRIG_EN defined, o_trig SHALL equal i_trig[grant] sampled with the lane-0 word; a trig on lanes 1..NPAR-1 SHALL set a sticky error bit o_trig_err (output, 1 bit, cleared by reset only).
REQ-028 Without XS2P_SCHED_TRIG_EN, o_trig SHALL be tied 0, i_trig SHALL be unused, and o_trig_err SHALL be absent.

Structure
REQ-029 Package xs2p_pkg SHALL hold the clog2 function and the FSM state encoding constants.
REQ-030 Round-robin selection SHALL be a sub-module xs2p_rr_arb (inputs: request vector, pointer; outputs: grant index, any-request flag), and SHALL be purely combinational.

Verification (NCH=4, BWID=8, NPAR=4)
REQ-031 Single channel: i_rdy=4'b0100, ch2 returns 0x11,0x22,0x33,0x44 -> one beat ov_data=0x44332211, ov_ch=2, o_dv at t+6.
REQ-032 Fairness: i_rdy=4'b1111 held for 8 beats -> ov_ch sequence 0,1,2,3,0,1,2,3 and o_rd one-hot throughout.
REQ-033 Backpressure: i_ordy=0 for 20 cycles -> first beat held stable, second burst parks in HOLD, no third o_rd; i_ordy=1 -> both beats delivered in order with no loss.
REQ-034 Reset on the 2nd read of a burst -> o_rd=0 next cycle, o_dv stays 0, next grant goes to ch0.
REQ-035 With XS2P_SCHED_TRIG_EN: trig on lane 0 of ch1 -> o_trig=1 with that beat; trig on lane 2 -> o_trig=0 and o_trig_err=1 until reset.

Source files
------------

// File: rtl/xs2p_pkg.sv
// Shared types and helpers for the serial-to-parallel scheduler.
package xs2p_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LAST = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Ceiling log2, never below 1 so that vectors stay at least 1 bit wide
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/xs2p_rr_arb.sv
// Combinational round-robin picker: first requester at or after the pointer.
module xs2p_rr_arb
  import xs2p_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         i_req,
  input  logic [clog2(NCH)-1:0]  i_ptr,
  output logic [clog2(NCH)-1:0]  o_gnt_c,
  output logic                   o_any_c
);

  localparam int unsigned CW = clog2(NCH);

  // Scan channels starting at the pointer, wrapping modulo NCH
  always_comb begin
    int unsigned idx;
    idx     = 0;
    o_gnt_c = '0;
    o_any_c = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (32'(i_ptr) + k) % NCH;
      if (!o_any_c && (|(i_req & (NCH'(1) << idx)))) begin
        o_any_c = 1'b1;
        o_gnt_c = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/xs2p_sched.sv
// Round-robin burst reader that packs NPAR serial words into one output beat.
// Optional frame-trigger tracking is enabled by defining XS2P_SCHED_TRIG_EN.
module xs2p_sched
  import xs2p_pkg::*;
#(
  parameter int unsigned BWID = 8,
  parameter int unsigned NPAR = 4,
  parameter int unsigned NCH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           i_rdy,
  output logic [NCH-1:0]           o_rd,
  input  logic [NCH*BWID-1:0]      iv_data,
  input  logic [NCH-1:0]           i_trig,
  output logic [BWID*NPAR-1:0]     ov_data,
  output logic [clog2(NCH)-1:0]    ov_ch,
  output logic                     o_dv,
  input  logic                     i_ordy,
`ifdef XS2P_SCHED_TRIG_EN
  output logic                     o_trig_err,
`endif
  output logic                     o_trig
);

  localparam int unsigned CW  = clog2(NCH);
  localparam int unsigned CNW = clog2(NPAR);
  localparam int unsigned BW  = BWID * NPAR;

  state_t          r_state, w_state_n;
  logic [CNW-1:0]  r_cnt, w_cnt_n;
  logic [CW-1:0]   r_gnt, w_gnt_n;
  logic [CW-1:0]   r_ptr, w_ptr_n;
  logic [NCH-1:0]  r_rd, w_rd_n;

  logic [CW-1:0]   w_win;
  logic            w_any;
  logic            w_free;
  logic            w_load;

  logic            r_cap_vld;
  logic [CNW-1:0]  r_cap_lane;
  logic [BWID-1:0] w_word;
  logic [BW-1:0]   r_beat, w_beat_n;

  logic [BW-1:0]   r_ov_data;
  logic [CW-1:0]   r_ov_ch;
  logic            r_dv;

  xs2p_rr_arb #(.NCH(NCH)) u_arb (
    .i_req   (i_rdy),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_win),
    .o_any_c (w_any)
  );

  assign w_free = !r_dv || i_ordy;
  assign w_load = ((r_state == ST_LAST) || (r_state == ST_HOLD)) && w_free;

  // Select the returning word of the granted channel
  always_comb begin
    w_word = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (r_gnt == CW'(c)) w_word = iv_data[c*BWID +: BWID];
    end
  end

  // Beat with the word returned this cycle merged into its lane
  always_comb begin
    w_beat_n = r_beat;
    for (int unsigned k = 0; k < NPAR; k++) begin
      if (r_cap_vld && (r_cap_lane == CNW'(k))) w_beat_n[k*BWID +: BWID] = w_word;
    end
  end

  // Next-state and read-strobe decode
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_gnt_n   = r_gnt;
    w_ptr_n   = r_ptr;
    w_rd_n    = r_rd;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_n = ST_RD;
          w_gnt_n   = w_win;
          w_ptr_n   = (w_win == CW'(NCH - 1)) ? '0 : w_win + CW'(1);
          w_cnt_n   = '0;
          w_rd_n    = NCH'(1) << w_win;
        end
      end
      ST_RD: begin
        if (r_cnt == CNW'(NPAR - 1)) begin
          w_state_n = ST_LAST;
          w_cnt_n   = '0;
          w_rd_n    = '0;
        end else begin
          w_cnt_n = r_cnt + CNW'(1);
        end
      end
      ST_LAST: begin
        w_state_n = w_free ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (w_free) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_gnt   <= w_gnt_n;
      r_ptr   <= w_ptr_n;
      r_rd    <= w_rd_n;
    end
  end

  // Read-latency pipeline, lane packing and output slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cap_vld  <= 1'b0;
      r_cap_lane <= '0;
      r_beat     <= '0;
      r_ov_data  <= '0;
      r_ov_ch    <= '0;
      r_dv       <= 1'b0;
    end else begin
      r_cap_vld  <= |r_rd;
      r_cap_lane <= r_cnt;
      r_beat     <= w_beat_n;
      if (w_load) begin
        r_ov_data <= w_beat_n;
        r_ov_ch   <= r_gnt;
        r_dv      <= 1'b1;
      end else if (i_ordy) begin
        r_dv <= 1'b0;
      end
    end
  end

  assign o_rd    = r_rd;
  assign ov_data = r_ov_data;
  assign ov_ch   = r_ov_ch;
  assign o_dv    = r_dv;

`ifdef XS2P_SCHED_TRIG_EN
  logic w_trig_sel;
  logic r_trig_lane0;
  logic r_trig_err;
  logic r_ov_trig;

  // Trigger bit of the granted channel, aligned with its data
  always_comb begin
    w_trig_sel = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (r_gnt == CW'(c)) w_trig_sel = i_trig[c];
    end
  end

  // Lane-0 trigger latch, sticky misplaced-trigger flag, output trigger
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_trig_lane0 <= 1'b0;
      r_trig_err   <= 1'b0;
      r_ov_trig    <= 1'b0;
    end else begin
      if (r_cap_vld) begin
        if (r_cap_lane == '0) r_trig_lane0 <= w_trig_sel;
        else if (w_trig_sel)  r_trig_err   <= 1'b1;
      end
      if (w_load) r_ov_trig <= r_trig_lane0;
    end
  end

  assign o_trig     = r_ov_trig;
  assign o_trig_err = r_trig_err;
`else
  logic w_unused_trig;
  assign w_unused_trig = ^i_trig;
  assign o_trig        = 1'b0;
`endif

endmodule

// File: tb/tb_xs2p_sched.sv
// Directed bench for xs2p_sched (NCH=4, BWID=8, NPAR=4).
module tb_xs2p_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_rdy;
  logic [3:0]  o_rd;
  logic [31:0] iv_data;
  logic [3:0]  i_trig;
  logic [31:0] ov_data;
  logic [1:0]  ov_ch;
  logic        o_dv;
  logic        i_ordy;
  logic        o_trig;
`ifdef XS2P_SCHED_TRIG_EN
  logic        o_trig_err;
`endif

  always #5 clk = ~clk;

  xs2p_sched #(.BWID(8), .NPAR(4), .NCH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rdy      (i_rdy),
    .o_rd       (o_rd),
    .iv_data    (iv_data),
    .i_trig     (i_trig),
    .ov_data    (ov_data),
    .ov_ch      (ov_ch),
    .o_dv       (o_dv),
    .i_ordy     (i_ordy),
`ifdef XS2P_SCHED_TRIG_EN
    .o_trig_err (o_trig_err),
`endif
    .o_trig     (o_trig)
  );

  int total = 0;
  int bad   = 0;

  logic idx_clr;
  logic trig_tab [4][64];
  int   rd_idx [4];

  int   rd_total   = 0;
  int   onehot_bad = 0;
  int   dv_total   = 0;
  logic [31:0] q_data [$];
  logic [1:0]  q_ch   [$];

  typedef struct {
    logic [3:0]  rdy;
    logic [1:0]  ch;
    logic [31:0] data;
  } vec_t;
  vec_t vt [6];

  // Word returned by channel c on its n-th read since reset
  function automatic logic [7:0] word(input int c, input int n);
    if (c == 2 && n < 4) return 8'(8'h11 * (n + 1));
    return {2'(c), 6'(n)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Channel model: a read strobe seen in cycle X returns data in cycle X+1
  initial begin
    logic [3:0] rd_s;
    iv_data = {4{8'hEE}};
    i_trig  = '0;
    for (int c = 0; c < 4; c++) rd_idx[c] = 0;
    forever begin
      @(negedge clk);
      rd_s = o_rd;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (idx_clr) rd_idx[c] = 0;
        if (rd_s[c]) begin
          iv_data[c*8 +: 8] = word(c, rd_idx[c]);
          i_trig[c]         = trig_tab[c][rd_idx[c] % 64];
          rd_idx[c]         = rd_idx[c] + 1;
        end else begin
          iv_data[c*8 +: 8] = 8'hEE;
          i_trig[c]         = 1'b0;
        end
      end
    end
  end

  // Output monitor: one-hot read strobe, accepted beats
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if ($countones(o_rd) > 1) onehot_bad++;
      if (o_rd != '0) rd_total++;
      if (o_dv) dv_total++;
      if (o_dv && i_ordy) begin
        q_data.push_back(ov_data);
        q_ch.push_back(ov_ch);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    idx_clr = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    idx_clr = 1'b0;
    @(negedge clk);
  endtask

  // Request once at a negedge, then wait for the beat (bounded)
  task automatic do_burst(input logic [3:0] rdy, output logic [31:0] d,
                          output logic [1:0] ch, output logic tg, output int lat);
    i_rdy = rdy;
    @(negedge clk);
    lat   = 1;
    i_rdy = '0;
    while (!o_dv && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d  = ov_data;
    ch = ov_ch;
    tg = o_trig;
  endtask

  initial begin
    logic [31:0] d, e, held;
    logic [1:0]  ch;
    logic        tg, seen;
    int          lat, qb, rb, db, unstable, cyc;
    int          expn [4];

    rst     = 1'b0;
    i_rdy   = '0;
    i_ordy  = 1'b1;
    idx_clr = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int n = 0; n < 64; n++) trig_tab[c][n] = 1'b0;

    vt[0] = '{rdy: 4'b0100, ch: 2'd2, data: 32'h44332211};
    vt[1] = '{rdy: 4'b0001, ch: 2'd0, data: 32'h03020100};
    vt[2] = '{rdy: 4'b1001, ch: 2'd3, data: 32'hC3C2C1C0};
    vt[3] = '{rdy: 4'b0011, ch: 2'd0, data: 32'h07060504};
    vt[4] = '{rdy: 4'b0011, ch: 2'd1, data: 32'h43424140};
    vt[5] = '{rdy: 4'b0001, ch: 2'd0, data: 32'h0B0A0908};

    repeat (3) @(negedge clk);
    rst     = 1'b1;
    idx_clr = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_o_rd", 32'(o_rd), 32'd0);
    chk("rst_o_dv", 32'(o_dv), 32'd0);
    chk("rst_ov_data", ov_data, 32'd0);
    chk("rst_ov_ch", 32'(ov_ch), 32'd0);
    chk("rst_o_trig", 32'(o_trig), 32'd0);
`ifdef XS2P_SCHED_TRIG_EN
    chk("rst_trig_err", 32'(o_trig_err), 32'd0);
`endif

    // Single bursts: latency, packing, round-robin pointer
    for (int i = 0; i < 6; i++) begin
      do_burst(vt[i].rdy, d, ch, tg, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
      chk($sformatf("vec%0d_data", i), d, vt[i].data);
      chk($sformatf("vec%0d_ch", i), 32'(ch), 32'(vt[i].ch));
      chk($sformatf("vec%0d_trig", i), 32'(tg), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_dv_clear", i), 32'(o_dv), 32'd0);
    end

    // Fairness with all channels requesting
    do_reset();
    qb    = q_data.size();
    i_rdy = 4'hF;
    cyc   = 0;
    while ((q_data.size() - qb) < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    i_rdy = '0;
    repeat (12) @(negedge clk);
    chk("fair_count", 32'(q_data.size() - qb >= 8), 32'd1);
    for (int c = 0; c < 4; c++) expn[c] = 0;
    for (int k = 0; k < 8; k++) begin
      if (qb + k < q_data.size()) begin
        for (int l = 0; l < 4; l++) e[l*8 +: 8] = word(k % 4, expn[k % 4] + l);
        expn[k % 4] += 4;
        chk($sformatf("fair%0d_ch", k), 32'(q_ch[qb + k]), 32'(k % 4));
        chk($sformatf("fair%0d_data", k), q_data[qb + k], e);
      end
    end
    chk("rd_onehot", 32'(onehot_bad), 32'd0);

    // Backpressure: first beat held, second burst parks
    do_reset();
    i_ordy   = 1'b0;
    i_rdy    = 4'b0001;
    rb       = rd_total;
    seen     = 1'b0;
    held     = '0;
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_dv) begin
        if (!seen) begin
          held = ov_data;
          seen = 1'b1;
        end else if (ov_data !== held) begin
          unstable++;
        end
      end
    end
    #3;
    chk("bp_rd_cycles", 32'(rd_total - rb), 32'd8);
    chk("bp_held_data", held, 32'h03020100);
    chk("bp_stable", 32'(unstable), 32'd0);
    chk("bp_dv_held", 32'(o_dv), 32'd1);
    chk("bp_no_rd", 32'(o_rd), 32'd0);
    @(negedge clk);
    qb     = q_data.size();
    i_rdy  = '0;
    i_ordy = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_beats", 32'(q_data.size() - qb), 32'd2);
    if (q_data.size() - qb >= 2) begin
      chk("bp_beat0", q_data[qb], 32'h03020100);
      chk("bp_beat1", q_data[qb + 1], 32'h07060504);
      chk("bp_ch1", 32'(q_ch[qb + 1]), 32'd0);
    end

    // Reset on the second read of a burst
    do_reset();
    i_rdy = 4'b0100;
    @(negedge clk);
    i_rdy = '0;
    chk("mid_rd1", 32'(o_rd), 32'h4);
    @(negedge clk);
    rst     = 1'b0;
    idx_clr = 1'b1;
    @(negedge clk);
    chk("mid_rd_zero", 32'(o_rd), 32'd0);
    chk("mid_dv_zero", 32'(o_dv), 32'd0);
    rst     = 1'b1;
    idx_clr = 1'b0;
    #3;
    db = dv_total;
    repeat (8) @(negedge clk);
    chk("mid_no_beat", 32'(dv_total - db), 32'd0);
    i_rdy = 4'hF;
    @(negedge clk);
    i_rdy = '0;
    chk("mid_next_grant", 32'(o_rd), 32'h1);
    cyc = 0;
    while (!o_dv && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_next_ch", 32'(ov_ch), 32'd0);
    chk("mid_next_data", ov_data, 32'h03020100);
    @(negedge clk);

`ifdef XS2P_SCHED_TRIG_EN
    // Frame trigger on lane 0, then a misplaced one on lane 2
    do_reset();
    trig_tab[1][0] = 1'b1;
    trig_tab[1][6] = 1'b1;
    do_burst(4'b0010, d, ch, tg, lat);
    chk("trig0_o_trig", 32'(tg), 32'd1);
    chk("trig0_ch", 32'(ch), 32'd1);
    chk("trig0_err", 32'(o_trig_err), 32'd0);
    @(negedge clk);
    do_burst(4'b0010, d, ch, tg, lat);
    chk("trig2_o_trig", 32'(tg), 32'd0);
    chk("trig2_err", 32'(o_trig_err), 32'd1);
    @(negedge clk);
    do_burst(4'b0010, d, ch, tg, lat);
    chk("trig3_err_sticky", 32'(o_trig_err), 32'd1);
    @(negedge clk);
    do_reset();
    chk("trig_err_rst", 32'(o_trig_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
